// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared constants and state encoding for the ASCII sum encoder
//
// Purpose: ASCII code points, FSM state enumeration and a digit-to-character
// helper used by ascii_sum_encoder.
// Ports:   none (package).

package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV_H  = 3'd1,
    CONV_T  = 3'd2,
    EMIT_H  = 3'd3,
    EMIT_T  = 3'd4,
    EMIT_O  = 3'd5,
    EMIT_CR = 3'd6
  } state_e;

  // Decimal digit (0..9) to its ASCII character.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/ascii_sum_encoder.sv
// rtl/ascii_sum_encoder.sv - converts an 8-bit sum to a decimal ASCII character stream
//
// Purpose: on start, splits sum into hundreds/tens/ones by repeated
// subtraction, then emits the digits (leading zeros suppressed, inner zeros
// kept) over a valid/ready handshake, optionally followed by a CR.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   encode request, sampled only while idle
//   sum[7:0]   in   value to encode, captured when start is accepted
//   busy       out  encode in progress
//   char_data  out  ASCII character (0x00 when no character is offered)
//   char_valid out  char_data is valid
//   char_ready in   consumer takes char_data this cycle
//   done       out  one-cycle pulse after the final character transfer

module ascii_sum_encoder
  import ascii_pkg::*;
#(
  parameter int unsigned EMIT_TERM = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sum,
  output logic       busy,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       done
);

  state_e      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      hund_q  <= 2'd0;
      tens_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    done_d     = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;

    case (state_q)
      IDLE: begin
        // Also reached in the done cycle, so back-to-back requests need no gap.
        if (start) begin
          rem_d   = sum;
          hund_d  = 2'd0;
          tens_d  = 4'd0;
          state_d = CONV_H;
        end
      end

      CONV_H: begin
        if (rem_q >= 8'd100) begin
          rem_d  = rem_q - 8'd100;
          hund_d = hund_q + 2'd1;
        end else begin
          state_d = CONV_T;
        end
      end

      CONV_T: begin
        if (rem_q >= 8'd10) begin
          rem_d  = rem_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else if (hund_q != 2'd0) begin
          state_d = EMIT_H;
        end else if (tens_q != 4'd0) begin
          state_d = EMIT_T;
        end else begin
          // Covers sum == 0: a single '0' is still emitted.
          state_d = EMIT_O;
        end
      end

      EMIT_H: begin
        char_valid = 1'b1;
        char_data  = digit_char({2'b00, hund_q});
        // Always continue to tens so an inner zero (e.g. 205) is kept.
        if (char_ready) state_d = EMIT_T;
      end

      EMIT_T: begin
        char_valid = 1'b1;
        char_data  = digit_char(tens_q);
        if (char_ready) state_d = EMIT_O;
      end

      EMIT_O: begin
        char_valid = 1'b1;
        // After CONV_T the remainder is below 10, so the low nibble is the digit.
        char_data  = digit_char(rem_q[3:0]);
        if (char_ready) begin
          if (EMIT_TERM != 0) begin
            state_d = EMIT_CR;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      EMIT_CR: begin
        char_valid = 1'b1;
        char_data  = ASCII_CR;
        if (char_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_ascii_sum_encoder.sv
// tb/tb_ascii_sum_encoder.sv - directed self-checking bench for ascii_sum_encoder
//
// Purpose: drives directed encode requests into two instances (with and
// without the CR terminator) and checks streams, latency, done and reset.
// Ports:   none (top-level bench).

module tb_ascii_sum_encoder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] sum;
  logic       char_ready;

  logic       busy_t, valid_t, done_t;
  logic [7:0] data_t;
  logic       busy_n, valid_n, done_n;
  logic [7:0] data_n;

  bit         sel_term;
  logic       o_busy, o_valid, o_done;
  logic [7:0] o_data;

  int errors;
  int checks;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int first_lat;
  int done_lat;
  int busy_gap;

  ascii_sum_encoder #(.EMIT_TERM(1)) u_dut_term (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sum        (sum),
    .busy       (busy_t),
    .char_data  (data_t),
    .char_valid (valid_t),
    .char_ready (char_ready),
    .done       (done_t)
  );

  ascii_sum_encoder #(.EMIT_TERM(0)) u_dut_noterm (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sum        (sum),
    .busy       (busy_n),
    .char_data  (data_n),
    .char_valid (valid_n),
    .char_ready (char_ready),
    .done       (done_n)
  );

  assign o_busy  = sel_term ? busy_t  : busy_n;
  assign o_valid = sel_term ? valid_t : valid_n;
  assign o_done  = sel_term ? done_t  : done_n;
  assign o_data  = sel_term ? data_t  : data_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_char%0d", tag, i),
          (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  // Called at a negedge. Presents a request, then plays consumer until done.
  // stall: cycles to hold char_ready low on the first character (checked
  // against stall_char). inject_k: cycle at which start is pulsed with sum=99.
  task automatic encode(input logic [7:0] s, input int stall, input logic [7:0] stall_char,
                        input int inject_k);
    int  stl;
    int  last_k;
    bit  fin;
    got.delete();
    first_lat  = -1;
    done_lat   = -1;
    busy_gap   = 0;
    stl        = stall;
    last_k     = -1;
    fin        = 1'b0;
    sum        = s;
    start      = 1'b1;
    char_ready = 1'b1;
    for (int k = 1; k <= 80 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == inject_k) begin
        start = 1'b1;
        sum   = 8'd99;
      end
      if (o_done) begin
        fin      = 1'b1;
        done_lat = k - last_k;
      end else begin
        if (!o_busy) busy_gap++;
        if (o_valid) begin
          if (first_lat < 0) first_lat = k;
          if (stl > 0) begin
            char_ready = 1'b0;
            stl--;
            chk("stall_hold_data", 32'(o_data), 32'(stall_char));
          end else begin
            char_ready = 1'b1;
            got.push_back(o_data);
            last_k = k;
          end
        end else begin
          char_ready = 1'b1;
        end
      end
    end
    if (!fin) chk("encode_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seen_valid;
    int seen_done;
    errors     = 0;
    checks     = 0;
    sel_term   = 1'b1;
    rst        = 1'b1;
    start      = 1'b0;
    sum        = 8'd0;
    char_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_busy",  32'(o_busy),  32'(0));
    chk("reset_valid", 32'(o_valid), 32'(0));
    chk("reset_done",  32'(o_done),  32'(0));
    chk("reset_data",  32'(o_data),  32'(8'h00));

    rst = 1'b0;

    // sum=0: single '0' then CR
    encode(8'd0, 0, 8'h00, 0);
    exp_q = '{8'h30, 8'h0D};
    cmp_stream("sum0");
    chk("sum0_first_lat", 32'(first_lat), 32'(3));
    chk("sum0_done_lat",  32'(done_lat),  32'(1));
    chk("sum0_busy_gap",  32'(busy_gap),  32'(0));
    chk("sum0_busy_at_done",  32'(o_busy),  32'(0));
    chk("sum0_valid_at_done", 32'(o_valid), 32'(0));

    // sum=123 issued in the done cycle (back-to-back)
    encode(8'd123, 0, 8'h00, 0);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h0D};
    cmp_stream("sum123");
    chk("sum123_first_lat", 32'(first_lat), 32'(6));
    chk("sum123_done_lat",  32'(done_lat),  32'(1));
    @(negedge clk);
    chk("sum123_done_pulse_width", 32'(o_done), 32'(0));
    idle_cycles(2);

    // sum=205: inner zero kept
    encode(8'd205, 0, 8'h00, 0);
    exp_q = '{8'h32, 8'h30, 8'h35, 8'h0D};
    cmp_stream("sum205");
    chk("sum205_first_lat", 32'(first_lat), 32'(5));
    idle_cycles(4);

    // sum=255 on the instance without terminator
    sel_term = 1'b0;
    encode(8'd255, 0, 8'h00, 0);
    exp_q = '{8'h32, 8'h35, 8'h35};
    cmp_stream("sum255_noterm");
    chk("sum255_first_lat", 32'(first_lat), 32'(10));
    chk("sum255_done_lat",  32'(done_lat),  32'(1));
    sel_term = 1'b1;
    idle_cycles(4);

    // sum=47 with consumer stalled 5 cycles on the first character
    encode(8'd47, 5, 8'h34, 0);
    exp_q = '{8'h34, 8'h37, 8'h0D};
    cmp_stream("sum47_stall");
    chk("sum47_done_lat", 32'(done_lat), 32'(1));
    idle_cycles(4);

    // sum=12 with a start(sum=99) pulse during emission
    encode(8'd12, 0, 8'h00, 5);
    exp_q = '{8'h31, 8'h32, 8'h0D};
    cmp_stream("sum12_ignore_start");
    chk("sum12_busy_gap", 32'(busy_gap), 32'(0));
    seen_valid = 0;
    seen_done  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_valid) seen_valid++;
      if (o_done)  seen_done++;
    end
    chk("sum12_no_extra_chars", 32'(seen_valid), 32'(0));
    chk("sum12_single_done",    32'(seen_done),  32'(0));

    // reset while '2' of sum=200 is pending
    sum        = 8'd200;
    start      = 1'b1;
    char_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !o_valid; i++) @(negedge clk);
    chk("rst_pend_valid", 32'(o_valid), 32'(1));
    chk("rst_pend_data",  32'(o_data),  32'(8'h32));
    rst = 1'b1;
    #1;
    chk("rst_async_busy",  32'(o_busy),  32'(0));
    chk("rst_async_valid", 32'(o_valid), 32'(0));
    chk("rst_async_data",  32'(o_data),  32'(8'h00));
    chk("rst_async_done",  32'(o_done),  32'(0));
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_done", 32'(o_done), 32'(0));
    rst = 1'b0;
    encode(8'd7, 0, 8'h00, 0);
    exp_q = '{8'h37, 8'h0D};
    cmp_stream("sum7_after_rst");
    chk("sum7_first_lat", 32'(first_lat), 32'(3));
    chk("sum7_done_lat",  32'(done_lat),  32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
